// File: rtl/password_entry_tx_pkg.sv
// Shared types and constants for the password entry transmitter.
// State encoding, word layout and flag values used by the top and the digit buffer.
package password_entry_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ID_ENTRY = 3'd1,
        ID_SEND  = 3'd2,
        GAP      = 3'd3,
        PW_ENTRY = 3'd4,
        PW_SEND  = 3'd5
    } state_t;

    localparam int          DIGITS      = 4;
    localparam int          VALUE_W     = 16;
    localparam int          WORD_W      = 18;
    localparam int          COUNT_W     = 3;
    localparam logic [1:0]  FLAG_NONE   = 2'b00;
    localparam logic [1:0]  FLAG_CHANGE = 2'b01;

    // Word sent to the access controller: request flags above the 4-digit value.
    function automatic logic [WORD_W-1:0] make_word(input logic [1:0] flags,
                                                    input logic [VALUE_W-1:0] value);
        return {flags, value};
    endfunction

endpackage

// File: rtl/password_entry_tx_entry_shift_reg.sv
// entry_shift_reg: 16-bit MSB-first digit buffer with a saturating digit counter.
// Digits beyond the fourth are silently dropped; clear wins over shift.
module entry_shift_reg
    import password_entry_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 clear_en,
    input  logic [3:0]           code,
    output logic [VALUE_W-1:0]   value,
    output logic [COUNT_W-1:0]   digit_count,
    output logic                 full
);

    assign full = (digit_count == COUNT_W'(DIGITS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            value       <= '0;
            digit_count <= '0;
        end else if (clear_en) begin
            value       <= '0;
            digit_count <= '0;
        end else if (shift_en && !full) begin
            value       <= {value[VALUE_W-5:0], code};
            digit_count <= digit_count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/password_entry_tx.sv
// password_entry_tx: collects a 4-digit ID then password words from a keypad and strobes them out.
// Optional inactivity timeout is built only when ENTRY_TIMEOUT_EN is defined.
module password_entry_tx
    import password_entry_tx_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           key_code,
    input  logic                 key_valid,
    input  logic                 key_enter,
    input  logic                 key_clear,
    input  logic                 key_cancel,
    input  logic [1:0]           mode_sel,
    output logic [WORD_W-1:0]    data_out,
    output logic                 data_load,
    output logic [COUNT_W-1:0]   digit_count,
    output logic                 pw_phase,
    output logic                 entry_err,
    output logic                 timeout
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic                 shift_en;
    logic                 clear_en;
    logic                 load_word;
    logic                 err_next;
    logic [WORD_W-1:0]    word_next;
    logic [VALUE_W-1:0]   digit_buf;
    logic                 full;
    logic [3:0]           gap_cnt;
    logic                 in_entry;
    logic                 timeout_hit;

    assign in_entry = (state == ID_ENTRY) || (state == PW_ENTRY);
    assign pw_phase = (state == GAP) || (state == PW_ENTRY) || (state == PW_SEND);

    entry_shift_reg u_entry_shift_reg (
        .clk         (clk),
        .rst         (rst),
        .shift_en    (shift_en),
        .clear_en    (clear_en),
        .code        (key_code),
        .value       (digit_buf),
        .digit_count (digit_count),
        .full        (full)
    );

`ifdef ENTRY_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        any_key;

    assign any_key     = key_valid | key_enter | key_clear | key_cancel;
    assign timeout_hit = in_entry && !any_key && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Inactivity counter only runs while the user is expected to be typing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (any_key || !in_entry || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            data_out  <= '0;
            data_load <= 1'b0;
            entry_err <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_next;
            data_load <= load_word;
            entry_err <= err_next;
            if (load_word) begin
                data_out <= word_next;
            end
            if (state == GAP && state_next == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // The word is captured at commit so the strobe lines up with the SEND state.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        clear_en   = 1'b0;
        load_word  = 1'b0;
        err_next   = 1'b0;
        word_next  = data_out;

        if (key_cancel || timeout_hit) begin
            state_next = IDLE;
            clear_en   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (key_clear) begin
                        clear_en = 1'b1;
                    end else if (!key_enter && key_valid) begin
                        shift_en   = 1'b1;
                        state_next = ID_ENTRY;
                    end
                end
                ID_ENTRY, PW_ENTRY: begin
                    if (key_clear) begin
                        clear_en = 1'b1;
                    end else if (key_enter) begin
                        if (full) begin
                            load_word = 1'b1;
                            if (state == ID_ENTRY) begin
                                word_next  = make_word(mode_sel, digit_buf);
                                state_next = ID_SEND;
                            end else begin
                                word_next  = make_word(FLAG_NONE, digit_buf);
                                state_next = PW_SEND;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (key_valid) begin
                        shift_en = 1'b1;
                    end
                end
                ID_SEND, PW_SEND: begin
                    clear_en   = 1'b1;
                    state_next = GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_next = PW_ENTRY;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_password_entry_tx.sv
// Scoreboard bench for password_entry_tx: committed words are queued at stimulus time and
// popped by a monitor on every data_load. Define ENTRY_TIMEOUT_EN to exercise the timeout.
module tb_password_entry_tx;

    logic        clk;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_enter;
    logic        key_clear;
    logic        key_cancel;
    logic [1:0]  mode_sel;
    logic [17:0] data_out;
    logic        data_load;
    logic [2:0]  digit_count;
    logic        pw_phase;
    logic        entry_err;
    logic        timeout;

    int          vectors;
    int          miscompares;
    int          err_seen;
    logic        prev_load;
    logic [17:0] exp_q[$];
    logic [17:0] exp_word;

    password_entry_tx #(
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_enter   (key_enter),
        .key_clear   (key_clear),
        .key_cancel  (key_cancel),
        .mode_sel    (mode_sel),
        .data_out    (data_out),
        .data_load   (data_load),
        .digit_count (digit_count),
        .pw_phase    (pw_phase),
        .entry_err   (entry_err),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every strobe must match the oldest queued word and never repeat back-to-back.
    always @(negedge clk) begin
        if (data_load === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_load got %h required no strobe", data_out);
            end else begin
                exp_word = exp_q.pop_front();
                if (data_out !== exp_word) begin
                    miscompares++;
                    $display("[TB] FAIL load_word got %h required %h", data_out, exp_word);
                end
            end
            vectors++;
            if (prev_load === 1'b1) begin
                miscompares++;
                $display("[TB] FAIL load_spacing got consecutive strobes required single");
            end
        end
        if (entry_err === 1'b1) begin
            err_seen++;
        end
        prev_load = data_load;
    end

    task automatic check_output(input string name, input logic [17:0] actual,
                                input logic [17:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s got %h required %h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic enter, input logic clr,
                                  input logic cancel, input logic [3:0] code);
        key_valid  = valid;
        key_enter  = enter;
        key_clear  = clr;
        key_cancel = cancel;
        key_code   = code;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key_enter  = 1'b0;
        key_clear  = 1'b0;
        key_cancel = 1'b0;
        key_code   = 4'h0;
    endtask

    task automatic press(input logic [3:0] code);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, code);
    endtask

    task automatic enter();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        err_seen    = 0;
        prev_load   = 1'b0;
        rst         = 1'b0;
        key_valid   = 1'b0;
        key_enter   = 1'b0;
        key_clear   = 1'b0;
        key_cancel  = 1'b0;
        key_code    = 4'h0;
        mode_sel    = 2'b00;
        idle(3);
        check_output("reset_data_out", data_out, 18'h0);
        check_output("reset_count", 18'(digit_count), 18'h0);
        check_output("reset_pw_phase", 18'(pw_phase), 18'h0);
        check_output("reset_err", 18'(entry_err), 18'h0);
        check_output("reset_timeout", 18'(timeout), 18'h0);
        rst = 1'b1;
        idle(1);

        // ID commit with password-change flag
        mode_sel = 2'b01;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check_output("id_count", 18'(digit_count), 18'h4);
        exp_q.push_back(18'h11234);
        enter();
        idle(1);
        check_output("gap_pw_phase", 18'(pw_phase), 18'h1);
        press(4'hF); press(4'hF);
        check_output("gap_ignores_keys", 18'(digit_count), 18'h0);

        // First password word
        press(4'hA); press(4'hB); press(4'hC); press(4'hD);
        exp_q.push_back(18'h0ABCD);
        enter();
        idle(3);
        check_output("data_out_hold", data_out, 18'h0ABCD);
        check_output("pw_entry_phase", 18'(pw_phase), 18'h1);

        // Short entry is rejected but kept
        press(4'h5); press(4'h6);
        enter();
        idle(1);
        check_output("short_err_count", 18'(err_seen), 18'h1);
        check_output("short_keeps_digits", 18'(digit_count), 18'h2);
        press(4'h7); press(4'h8);
        exp_q.push_back(18'h05678);
        enter();
        idle(3);

        // Fifth digit ignored, then enter+cancel coincident
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
        check_output("saturated_count", 18'(digit_count), 18'h4);
        exp_q.push_back(18'h01234);
        enter();
        idle(3);
        press(4'h1); press(4'h2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
        check_output("cancel_pw_phase", 18'(pw_phase), 18'h0);
        check_output("cancel_count", 18'(digit_count), 18'h0);
        idle(4);

        // Clear beats a coincident digit; clear in PW_ENTRY keeps state
        press(4'h3);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h7);
        check_output("clear_count", 18'(digit_count), 18'h0);
        mode_sel = 2'b10;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        exp_q.push_back(18'h21234);
        enter();
        idle(3);
        press(4'h9);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check_output("pw_clear_phase", 18'(pw_phase), 18'h1);
        press(4'h1); press(4'h2); press(4'h3);
        check_output("pre_reset_count", 18'(digit_count), 18'h3);

        // Mid-session reset overrides a coincident digit
        rst       = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'h4;
        idle(1);
        check_output("midrst_data_out", data_out, 18'h0);
        check_output("midrst_load", 18'(data_load), 18'h0);
        check_output("midrst_count", 18'(digit_count), 18'h0);
        check_output("midrst_pw_phase", 18'(pw_phase), 18'h0);
        check_output("midrst_err", 18'(entry_err), 18'h0);
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        idle(2);

        // Inactivity: one digit then eight quiet cycles
        press(4'h1);
        idle(8);
`ifdef ENTRY_TIMEOUT_EN
        check_output("timeout_pulse", 18'(timeout), 18'h1);
        check_output("timeout_count", 18'(digit_count), 18'h0);
        idle(1);
        check_output("timeout_single", 18'(timeout), 18'h0);
`else
        check_output("no_timeout", 18'(timeout), 18'h0);
        check_output("no_timeout_count", 18'(digit_count), 18'h1);
`endif
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        idle(3);
        check_output("pending_words", 18'(exp_q.size()), 18'h0);
        check_output("total_errors", 18'(err_seen), 18'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
